// File: rtl/trig_pkg.sv
// Shared types, constants and the elaboration-time sine generator for the
// trigonometric lookup unit.
package trig_pkg;

    typedef enum logic {
        TRIG_SIN = 1'b0,
        TRIG_COS = 1'b1
    } trig_mode_e;

    localparam int unsigned DEG_QUARTER = 90;
    localparam int unsigned DEG_FULL    = 360;
    localparam int unsigned ROM_DEPTH   = 91;
    localparam int unsigned ROM_IDX_W   = 7;
    localparam logic [31:0] FP_ZERO     = 32'h00000000;
    localparam logic [31:0] FP_ONE      = 32'h3F800000;

    // Binary32 encoding of sin(deg) for deg in 0..90, rounded to nearest-even.
    // Evaluated only at elaboration to fill the quarter table; angles above 45
    // use the cosine series of the complement so both series stay short.
    function automatic logic [31:0] trig_sin_bits(input int unsigned deg);
        real         x;
        real         term;
        real         sum;
        real         m;
        real         mant_r;
        real         frac;
        int          e;
        int          r;
        logic [31:0] rb;
        bit          use_cos;
        if (deg == 0) return FP_ZERO;
        if (deg >= DEG_QUARTER) return FP_ONE;
        use_cos = (deg > 45);
        x = (use_cos ? real'(DEG_QUARTER - deg) : real'(deg)) * 3.14159265358979323846 / 180.0;
        term = use_cos ? 1.0 : x;
        sum  = term;
        for (int unsigned k = 1; k < 24; k++) begin
            if (use_cos)
                term = -term * x * x / (real'(2 * k - 1) * real'(2 * k));
            else
                term = -term * x * x / (real'(2 * k) * real'(2 * k + 1));
            sum = sum + term;
        end
        m = sum;
        e = 0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (m < 1.0) begin
                m = m * 2.0;
                e = e - 1;
            end
        end
        mant_r = m * 8388608.0;
        r      = $rtoi(mant_r);
        frac   = mant_r - real'(r);
        if (frac > 0.5 || (frac == 0.5 && r[0])) r = r + 1;
        if (r == 16777216) begin
            r = 8388608;
            e = e + 1;
        end
        rb = 32'(r);
        return {1'b0, 8'(e + 127), rb[22:0]};
    endfunction

endpackage

// File: rtl/trig_quarter_rom.sv
// Quarter-wave sine table: sin(0..90 degrees) as binary32, combinational read.
module trig_quarter_rom
    import trig_pkg::*;
(
    input  logic [6:0]  idx,
    output logic [31:0] value
);

    logic [31:0] rom_w [ROM_DEPTH];

    for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_entry
        localparam logic [31:0] ENTRY = trig_sin_bits(i);
        assign rom_w[i] = ENTRY;
    end

    // Table read; indices past 90 never arrive from the fold, but read as zero.
    always_comb begin
        value = FP_ZERO;
        if (idx < 7'(ROM_DEPTH)) value = rom_w[idx];
    end

endmodule

// File: rtl/trig_lut_unit.sv
// Sine/cosine of an integer-degree angle via quadrant folding and a quarter
// table. Two-stage valid/ready pipeline: S1 folds, S2 looks up and signs.
module trig_lut_unit
    import trig_pkg::*;
#(
    parameter int unsigned ANGLE_W = 32,
    parameter int unsigned TAG_W   = 4
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ANGLE_W-1:0] in_angle,
    input  logic               in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_value,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_err
);

    localparam int unsigned EXT_W = ANGLE_W + 1;

    logic               adv;
    logic [EXT_W-1:0]   ang_ext;
    logic [9:0]         eff;
    logic [8:0]         rem;
    logic [1:0]         quad;
    logic               fold_err;
    logic [6:0]         fold_idx;
    logic               fold_neg;
    logic [31:0]        rom_val;
    logic [31:0]        lookup_val;

    logic               s1_valid_d, s1_valid_q;
    logic [6:0]         s1_idx_d,   s1_idx_q;
    logic               s1_neg_d,   s1_neg_q;
    logic               s1_err_d,   s1_err_q;
    logic [TAG_W-1:0]   s1_tag_d,   s1_tag_q;
    logic               s2_valid_d, s2_valid_q;
    logic [31:0]        s2_value_d, s2_value_q;
    logic [TAG_W-1:0]   s2_tag_d,   s2_tag_q;
    logic               s2_err_d,   s2_err_q;

    assign adv      = !s2_valid_q || out_ready;
    assign in_ready = adv;

    // Fold the request angle into a quarter-table index and a sign.
    // Range check uses the full zero-extended angle; a legal angle is below
    // 360, so the cosine shift only needs its low 9 bits, and for an illegal
    // angle the folded index is don't-care because the error forces zero.
    always_comb begin
        ang_ext  = {1'b0, in_angle};
        fold_err = (ang_ext >= EXT_W'(DEG_FULL));
        eff      = {1'b0, in_angle[8:0]};
        if (trig_mode_e'(in_mode) == TRIG_COS) begin
            eff = eff + 10'(DEG_QUARTER);
            if (eff >= 10'(DEG_FULL)) eff = eff - 10'(DEG_FULL);
        end
        if (eff < 10'(DEG_QUARTER)) begin
            quad = 2'd0;
            rem  = eff[8:0];
        end else if (eff < 10'(2 * DEG_QUARTER)) begin
            quad = 2'd1;
            rem  = 9'(eff - 10'(DEG_QUARTER));
        end else if (eff < 10'(3 * DEG_QUARTER)) begin
            quad = 2'd2;
            rem  = 9'(eff - 10'(2 * DEG_QUARTER));
        end else begin
            quad = 2'd3;
            rem  = 9'(eff - 10'(3 * DEG_QUARTER));
        end
        fold_idx = quad[0] ? 7'(9'(DEG_QUARTER) - rem) : 7'(rem);
        fold_neg = quad[1];
    end

    trig_quarter_rom u_rom (
        .idx   (s1_idx_q),
        .value (rom_val)
    );

    // Apply sign to the table value; zero magnitude and range errors give +0.
    always_comb begin
        lookup_val = {s1_neg_q ^ rom_val[31], rom_val[30:0]};
        if (s1_err_q || rom_val[30:0] == 31'd0) lookup_val = FP_ZERO;
    end

    // Next-state for both stages; everything holds while the output stalls.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_idx_d   = s1_idx_q;
        s1_neg_d   = s1_neg_q;
        s1_err_d   = s1_err_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_value_d = s2_value_q;
        s2_tag_d   = s2_tag_q;
        s2_err_d   = s2_err_q;
        if (adv) begin
            s1_valid_d = in_valid;
            s1_idx_d   = fold_idx;
            s1_neg_d   = fold_neg;
            s1_err_d   = fold_err;
            s1_tag_d   = in_tag;
            s2_valid_d = s1_valid_q;
            s2_value_d = lookup_val;
            s2_tag_d   = s1_tag_q;
            s2_err_d   = s1_err_q;
        end
    end

    // Pipeline registers with synchronous reset that drops all in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            s1_neg_q   <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_value_q <= FP_ZERO;
            s2_tag_q   <= '0;
            s2_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_idx_q   <= s1_idx_d;
            s1_neg_q   <= s1_neg_d;
            s1_err_q   <= s1_err_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_value_q <= s2_value_d;
            s2_tag_q   <= s2_tag_d;
            s2_err_q   <= s2_err_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_value = s2_value_q;
    assign out_tag   = s2_tag_q;
    assign out_err   = s2_err_q;

endmodule

// File: doc/trig_lut_unit.md
TRIG_LUT_UNIT -- requirements
Module: trig_lut_unit

Interface
REQ-001 Parameter ANGLE_W, default 32: width of the integer-degree angle input.
REQ-002 Parameter TAG_W, default 4: width of the opaque request tag carried with each request.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  unit accepts the request this cycle.
REQ-007 in_angle  input  ANGLE_W  angle in whole degrees, unsigned.
REQ-008 in_mode  input  1  0 = sine, 1 = cosine.
REQ-009 in_tag  input  TAG_W  returned unchanged with the result.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 out_value  output  32  IEEE-754 single-precision result.
REQ-013 out_tag  output  TAG_W  tag of the request that produced this result.
REQ-014 out_err  output  1  request angle was 360 or greater.

Function
REQ-015 Handshakes: a request transfers when in_valid && in_ready; a result transfers when out_valid && out_ready.
REQ-016 Pipeline: two registered stages, S1 (fold) and S2 (lookup and sign); an accepted request yields out_valid exactly 2 cycles later when there is no backpressure.
REQ-017 Advance rule: adv = !S2.valid || out_ready; both stages load only when adv = 1; in_ready = adv (combinational).
REQ-018 Throughput: one result per cycle while out_ready stays 1; no bubbles are inserted.
REQ-019 Backpressure: with out_ready = 0 and S2 full, out_value, out_tag and out_err hold stable and no request is lost or duplicated.
REQ-020 Effective angle: e = in_angle for sine, e = (in_angle + 90) mod 360 for cosine; add at ANGLE_W+1 bits so there is no overflow.
REQ-021 Folding: quadrant q = e / 90, remainder r = e mod 90.
  - q = 0: index r, positive.
  - q = 1: index 90 - r, positive.
  - q = 2: index r, negative.
  - q = 3: index 90 - r, negative.
REQ-022 S1 registers index (7 bits), neg, err, tag and valid.
REQ-023 S2 reads the quarter ROM at the index; out_value = {neg ^ rom[31], rom[30:0]}.
REQ-024 Zero sign: when the ROM magnitude is +0, out_value = 32'h00000000 regardless of neg (no -0).
REQ-025 Range error: in_angle >= 360 sets out_err = 1 and out_value = 0 at normal latency; the cosine +90 is checked against the raw in_angle only.
REQ-026 Quarter ROM: 91 entries for sin(0..90) degrees, correctly rounded binary32.
  - Entry 0 = 32'h00000000.
  - Entry 30 = 32'h3F000000.
  - Entry 90 = 32'h3F800000.
  - No gaps; every index 0..90 is populated.

Reset
REQ-027 While rst = 1 at a clock edge: all stage valids clear, so out_valid = 0; out_value = 0, out_tag = 0, out_err = 0.
REQ-028 Reset mid-operation discards every in-flight request; no result from it ever appears.
REQ-029 in_ready = 1 in the first cycle after rst deasserts.

Structure
REQ-030 Package trig_pkg holds:
  - typedef trig_mode_e {TRIG_SIN, TRIG_COS};
  - constants DEG_QUARTER = 90, DEG_FULL = 360, FP_ZERO = 32'h00000000, FP_ONE = 32'h3F800000, ROM_DEPTH = 91.
REQ-031 The table is the sub-module trig_quarter_rom: 7-bit index in, 32-bit value out, combinational read sampled by the S2 register; the top level contains only fold, pipeline and handshake logic.

Verification
REQ-032 Sine sweep: sine for angles 0, 30, 90, 180, 210, 270, 359 -> out_value 00000000, 3F000000, 3F800000, 00000000, BF000000, BF800000, -rom[1]; each exactly 2 cycles after acceptance.
REQ-033 Cosine: cosine of 0, 60, 180, 270 -> 3F800000, 3F000000, BF800000, 00000000; no -0 appears.
REQ-034 Range error: sine of 360 and of 32'hFFFFFFFF -> out_err = 1, out_value = 0; the next legal request (sine 30) -> 3F000000 with out_err = 0.
REQ-035 Backpressure: stream 8 tagged requests (tags 0..7) with out_ready toggling randomly.
  - Tags emerge in order, with none dropped or duplicated.
  - Outputs stay stable while out_ready = 0.
  - in_ready = 0 whenever S2 is full and out_ready = 0.
REQ-036 Reset: assert rst with 2 requests in flight -> out_valid = 0 the next cycle, in_ready = 1 after release, and the flushed tags never appear.
REQ-037 Throughput: out_ready held at 1 and 100 back-to-back requests -> 100 results in 102 cycles, checked against a real-valued sin/cos model within 1 ULP.
